// File: rtl/calc_seq_ctrl.sv
// Keypad sequencer for the 13-bit calculator: accumulates decimal operands A/B,
// records the operator, and drives the state code decoded by the result mux and ALU.
module calc_seq_ctrl #(
  parameter int WIDTH   = 13,
  parameter int MAX_VAL = 8191
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic [WIDTH-1:0] sum_in,
  output logic             key_ready,
  output logic [5:0]       state,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             neg,
  output logic             err
);

  localparam int CW = WIDTH + 4;
  localparam logic [CW-1:0] MaxCand = CW'(MAX_VAL);

  typedef enum logic [5:0] {
    S_START      = 6'd0,
    S_SET_A      = 6'd1,
    S_SET_A_TEN  = 6'd2,
    S_SET_A_HUN  = 6'd3,
    S_SET_A_THUN = 6'd4,
    S_SET_B      = 6'd5,
    S_SET_B_TEN  = 6'd6,
    S_SET_B_HUN  = 6'd7,
    S_SET_B_THUN = 6'd8,
    S_ADD        = 6'd9,
    S_SUB        = 6'd10,
    S_SUM        = 6'd11,
    S_MUL        = 6'd12,
    S_ALU        = 6'd13
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             neg_q, neg_d, err_q, err_d;
  op_e              op_q, op_d;

  logic             key_fire, is_digit, is_op, is_eq, is_clear, is_rsvd;
  logic             in_exec;
  op_e              key_op;
  logic [WIDTH-1:0] digit;
  logic [CW-1:0]    cand_a, cand_b;

  assign in_exec  = (state_q == S_ADD) || (state_q == S_SUB) || (state_q == S_MUL);
  assign key_fire = key_valid && !in_exec;
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd12);
  assign is_eq    = (key_code == 4'd13);
  assign is_clear = (key_code == 4'd14);
  assign is_rsvd  = (key_code == 4'd15);
  assign digit    = {{(WIDTH-4){1'b0}}, key_code};

  // Wide candidate so operand*10+digit cannot wrap before the range check.
  assign cand_a = {4'b0000, a_q} * CW'(10) + {4'b0000, digit};
  assign cand_b = {4'b0000, b_q} * CW'(10) + {4'b0000, digit};

  always_comb begin
    key_op = OP_ADD;
    case (key_code)
      4'd11:   key_op = OP_SUB;
      4'd12:   key_op = OP_MUL;
      default: key_op = OP_ADD;
    endcase
  end

  // NOTE: state register uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers, regardless of process ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_START;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      op_q    <= op_d;
    end
  end

  // NOTE: every next-state signal gets a hold default first, so no path
  // through the case below leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    op_d    = op_q;
    err_d   = 1'b0;

    if (in_exec) begin
      state_d = S_SUM;
      neg_d   = (op_q == OP_SUB) && (b_q > a_q);
    end else if (key_fire) begin
      if (is_clear) begin
        state_d = S_START;
        a_d     = '0;
        b_d     = '0;
        neg_d   = 1'b0;
        op_d    = OP_ADD;
      end else if (is_rsvd) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          S_START: begin
            if (is_digit) begin
              a_d     = digit;
              state_d = S_SET_A;
            end else if (is_op) begin
              a_d     = '0;
              op_d    = key_op;
              state_d = S_ALU;
            end
          end
          S_SET_A, S_SET_A_TEN, S_SET_A_HUN, S_SET_A_THUN: begin
            if (is_digit) begin
              if (state_q == S_SET_A_THUN || cand_a > MaxCand) begin
                err_d = 1'b1;
              end else begin
                a_d     = cand_a[WIDTH-1:0];
                state_d = state_e'(state_q + 6'd1);
              end
            end else if (is_op) begin
              op_d    = key_op;
              b_d     = '0;
              state_d = S_ALU;
            end else if (is_eq) begin
              err_d = 1'b1;
            end
          end
          S_ALU: begin
            if (is_digit) begin
              b_d     = digit;
              state_d = S_SET_B;
            end else if (is_op) begin
              op_d = key_op;
            end else if (is_eq) begin
              err_d = 1'b1;
            end
          end
          S_SET_B, S_SET_B_TEN, S_SET_B_HUN, S_SET_B_THUN: begin
            if (is_digit) begin
              if (state_q == S_SET_B_THUN || cand_b > MaxCand) begin
                err_d = 1'b1;
              end else begin
                b_d     = cand_b[WIDTH-1:0];
                state_d = state_e'(state_q + 6'd1);
              end
            end else if (is_eq) begin
              case (op_q)
                OP_SUB:  state_d = S_SUB;
                OP_MUL:  state_d = S_MUL;
                default: state_d = S_ADD;
              endcase
            end else if (is_op) begin
              err_d = 1'b1;
            end
          end
          S_SUM: begin
            if (is_digit) begin
              a_d     = digit;
              b_d     = '0;
              neg_d   = 1'b0;
              state_d = S_SET_A;
            end else if (is_op) begin
              // Chaining: the previous result becomes the new operand A.
              a_d     = sum_in;
              b_d     = '0;
              neg_d   = 1'b0;
              op_d    = key_op;
              state_d = S_ALU;
            end
          end
          default: state_d = S_START;
        endcase
      end
    end
  end

  always_comb begin
    key_ready = !in_exec;
    state     = state_q;
    A         = a_q;
    B         = b_q;
    neg       = neg_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: a phase/digit-count reference model predicts
// the registered outputs after every clock; a monitor compares them one cycle later.
module tb_calc_seq_ctrl;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic [W-1:0] sum_in = '0;
  logic         key_ready;
  logic [5:0]   state;
  logic [W-1:0] A, B;
  logic         neg, err;

  calc_seq_ctrl #(.WIDTH(W), .MAX_VAL(8191)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code),
    .sum_in(sum_in), .key_ready(key_ready), .state(state),
    .A(A), .B(B), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]   st;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         neg;
    logic         err;
    logic         rdy;
  } snap_t;

  snap_t sb[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: phase plus number of digits typed, plain integer operands.
  typedef enum int {P_START, P_A, P_ALU, P_B, P_EXEC, P_SUM} phase_e;
  phase_e m_phase;
  int     m_a, m_b, m_na, m_nb, m_op;  // op: 0 add, 1 sub, 2 mul
  bit     m_neg, m_err;
  int     sum_val = 0;

  task automatic m_reset();
    m_phase = P_START; m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
    m_op = 0; m_neg = 0;
  endtask

  function automatic snap_t m_snap();
    snap_t s;
    int code;
    case (m_phase)
      P_START: code = 0;
      P_A:     code = m_na;
      P_ALU:   code = 13;
      P_B:     code = 4 + m_nb;
      P_EXEC:  code = (m_op == 1) ? 10 : (m_op == 2) ? 12 : 9;
      default: code = 11;
    endcase
    s.st  = 6'(code);
    s.a   = W'(m_a);
    s.b   = W'(m_b);
    s.neg = m_neg;
    s.err = m_err;
    s.rdy = (m_phase != P_EXEC);
    return s;
  endfunction

  task automatic m_step(input bit c, input bit kv, input int k, input int sum);
    bit dig, opk, eq;
    m_err = 0;
    dig = (k <= 9); opk = (k >= 10 && k <= 12); eq = (k == 13);
    if (c) begin
      m_reset();
    end else if (m_phase == P_EXEC) begin
      m_neg = (m_op == 1) && (m_b > m_a);
      m_phase = P_SUM;
    end else if (kv) begin
      if (k == 14) m_reset();
      else if (k == 15) m_err = 1;
      else case (m_phase)
        P_START: begin
          if (dig) begin m_a = k; m_na = 1; m_phase = P_A; end
          else if (opk) begin m_a = 0; m_op = k - 10; m_phase = P_ALU; end
        end
        P_A: begin
          if (dig) begin
            if (m_na == 4 || m_a * 10 + k > 8191) m_err = 1;
            else begin m_a = m_a * 10 + k; m_na++; end
          end else if (opk) begin m_op = k - 10; m_b = 0; m_phase = P_ALU; end
          else if (eq) m_err = 1;
        end
        P_ALU: begin
          if (dig) begin m_b = k; m_nb = 1; m_phase = P_B; end
          else if (opk) m_op = k - 10;
          else if (eq) m_err = 1;
        end
        P_B: begin
          if (dig) begin
            if (m_nb == 4 || m_b * 10 + k > 8191) m_err = 1;
            else begin m_b = m_b * 10 + k; m_nb++; end
          end else if (eq) m_phase = P_EXEC;
          else if (opk) m_err = 1;
        end
        default: begin
          if (dig) begin
            m_a = k; m_b = 0; m_neg = 0; m_na = 1; m_phase = P_A;
          end else if (opk) begin
            m_a = sum; m_b = 0; m_neg = 0; m_op = k - 10; m_phase = P_ALU;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit c, input bit kv, input int k);
    @(negedge clk);
    clr = c; key_valid = kv; key_code = 4'(k); sum_in = W'(sum_val);
    m_step(c, kv, k, sum_val);
    sb.push_back(m_snap());
  endtask

  task automatic key(input int k);
    step(1'b0, 1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, int'($urandom_range(0, 15)));
  endtask

  task automatic check(input string name, input snap_t got, input snap_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d A=%0d B=%0d neg=%b err=%b rdy=%b, want st=%0d A=%0d B=%0d neg=%b err=%b rdy=%b",
               name, got.st, got.a, got.b, got.neg, got.err, got.rdy,
               exp.st, exp.a, exp.b, exp.neg, exp.err, exp.rdy);
    end
  endtask

  // Monitor: outputs settle after each edge; compare against the oldest prediction.
  initial begin
    snap_t got, exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        got.st = state; got.a = A; got.b = B;
        got.neg = neg; got.err = err; got.rdy = key_ready;
        check($sformatf("cycle@%0t", $time), got, exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion before 1000000");
    $fatal(1);
  end

  initial begin
    int r;
    m_reset();
    m_err = 0;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    idle(1);

    // 12 + 34, then subtract with B > A, then subtract with B < A
    key(1); key(2); key(10); key(3); key(4); key(13); idle(2);
    key(5); key(11); key(9); key(13); step(1'b0, 1'b1, 5); idle(2);
    key(7); key(11); key(3); key(13); idle(2);

    // Range limits and fifth-digit rejection
    key(14); key(8); key(1); key(9); key(1); idle(1);
    key(14); key(8); key(1); key(9); key(3); idle(1);
    key(14); key(1); key(2); key(3); key(4); key(5); idle(1);

    // Chaining on a previous result of 46
    key(14); key(2); key(3); key(10); key(2); key(3); key(13);
    sum_val = 46; idle(2);
    key(12); key(2); key(13); idle(2);

    // clr with a key, clear in set_b_ten, equals in set_a_ten, reserved code
    key(3); step(1'b1, 1'b1, 4); idle(1);
    key(6); key(11); key(1); key(2); key(14); idle(1);
    key(4); key(4); key(13); key(15); idle(1);
    key(14); key(13); key(11); key(13); key(12); key(9); key(13); idle(2);

    // Randomised keys against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) sum_val = int'($urandom_range(0, 8191));
      r = int'($urandom_range(0, 99));
      if (r == 0)      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      else if (r < 55) key(int'($urandom_range(0, 9)));
      else if (r < 70) key(int'($urandom_range(10, 12)));
      else if (r < 82) key(13);
      else if (r < 85) key(14);
      else if (r < 87) key(15);
      else             idle(1);
    end

    idle(1);
    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
